ahb_sram_ctrl: RTL and testbench

Parametrised AHB-Lite slave fronting an on-chip single-port synchronous SRAM. It generalises the team's zero-wait AHB SRAM bridge in four ways: configurable data width and memory depth, programmable read wait states, a two-cycle ERROR response for illegal accesses, and correct HREADY qualification. It keeps the single-entry posted-write buffer with byte-merge read forwarding. It sits on the system AHB matrix as the main RAM slave.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/sram_sp.sv | 25 ++
 rtl/ahb_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, controller FSM states and byte-strobe helper
// shared by ahb_sram_ctrl.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} state_t;

   // Lane mask for a transfer of 2**size bytes at lane offset lo, clipped to the bus width.
   function automatic logic [7:0] gen_strb(input logic [2:0] size, input logic [2:0] lo, input int bytes);
      logic [15:0] m;
      m = ((16'd1 << (5'd1 << size)) - 16'd1) << lo;
      return m[7:0] & 8'((16'd1 << bytes) - 16'd1);
   endfunction

endpackage

// File: rtl/sram_sp.sv
// sram_sp: behavioural single-port synchronous RAM, byte write enables,
// one-cycle read latency, read-first; stands in for the FPGA block RAM.
module sram_sp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16384,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (en) begin
         dout <= mem[addr];
         for (int i = 0; i < DATA_W/8; i++)
            if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite SRAM slave with posted-write buffer, read forwarding,
// programmable read wait states and ERROR response. Option: AHB_SRAM_ACT_LED_EN adds leds_o.
module ahb_sram_ctrl
   import ahb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 65536,
   parameter int RD_WAIT   = 0,
   parameter int LED_HOLD  = 25000000
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic [1:0]        HTRANS,
   input  logic              HREADY,
   input  logic [DATA_W-1:0] HWDATA,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP
`ifdef AHB_SRAM_ACT_LED_EN
   ,
   output logic [1:0]        leds_o
`endif
);

   localparam int B     = DATA_W / 8;
   localparam int BL    = $clog2(B);
   localparam int DEPTH = MEM_BYTES / B;
   localparam int AW    = $clog2(DEPTH);

   state_t state, state_nx;
   logic [1:0] cnt;
   logic acc, illegal, rd_acc, wr_acc, drain, unused_ok;
   logic buf_valid, wr_dphase, rd_dphase, fwd_hit;
   logic [31-BL:0] buf_addr;
   logic [B-1:0] buf_strb, strb_new, fwd_strb;
   logic [DATA_W-1:0] buf_data, wdata_cur, fwd_data, hold, merged;
   logic ram_en;
   logic [B-1:0] ram_we;
   logic [AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dout;

   assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

   assign acc     = HSEL & HREADY & HTRANS[1] & HREADYOUT;
   assign illegal = (HSIZE > 3'(BL)) | (|(HADDR[2:0] & 3'((1 << HSIZE) - 1))) | (HADDR >= 32'(MEM_BYTES));
   assign rd_acc  = acc & ~illegal & ~HWRITE;
   assign wr_acc  = acc & ~illegal & HWRITE;
   assign strb_new = B'(gen_strb(HSIZE, 3'(HADDR[BL-1:0]), B));

   // While the buffered write is in its data phase the buffer register is not loaded yet.
   assign wdata_cur = wr_dphase ? HWDATA : buf_data;
   assign drain     = buf_valid & ~rd_acc;
   assign ram_en    = rd_acc | drain;
   assign ram_we    = drain ? buf_strb : '0;
   assign ram_addr  = rd_acc ? HADDR[AW+BL-1:BL] : buf_addr[AW-1:0];

   sram_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk (HCLK),
      .en  (ram_en),
      .we  (ram_we),
      .addr(ram_addr),
      .din (wdata_cur),
      .dout(ram_dout)
   );

   for (genvar i = 0; i < B; i++) begin : g_lane
      assign merged[8*i +: 8] = (fwd_hit & fwd_strb[i]) ? fwd_data[8*i +: 8] : ram_dout[8*i +: 8];
   end

   assign HREADYOUT = (state == ERR1) ? 1'b0 : (state == RWAIT) ? (cnt == 2'd0) : 1'b1;
   assign HRESP     = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = (RD_WAIT == 0) ? (rd_dphase ? merged : '0) : hold;

   always_comb begin
      state_nx = state;
      state_nx = acc ? (illegal ? ERR1 : (!HWRITE && RD_WAIT != 0) ? RWAIT : IDLE)
                     : (state == ERR1) ? ERR2
                     : (state == RWAIT && cnt != 2'd0) ? RWAIT : IDLE;
   end

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_strb  <= '0;
         buf_data  <= '0;
         wr_dphase <= 1'b0;
         rd_dphase <= 1'b0;
         fwd_hit   <= 1'b0;
         fwd_strb  <= '0;
         fwd_data  <= '0;
         hold      <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= rd_acc ? 2'(RD_WAIT) : cnt - 2'(cnt != 2'd0);
         wr_dphase <= wr_acc;
         rd_dphase <= rd_acc;
         buf_valid <= wr_acc | (buf_valid & ~drain);
         if (wr_dphase) buf_data <= HWDATA;
         if (wr_acc) begin
            buf_addr <= HADDR[31:BL];
            buf_strb <= strb_new;
         end
         if (rd_acc) begin
            fwd_hit  <= buf_valid & (buf_addr == HADDR[31:BL]);
            fwd_strb <= buf_strb;
            fwd_data <= wdata_cur;
         end
         if (rd_dphase) hold <= merged;
      end

`ifdef AHB_SRAM_ACT_LED_EN
   localparam int LW = $clog2(LED_HOLD + 1);
   logic [1:0] led_hit;
   assign led_hit = {|ram_we, ram_en & ~|ram_we};
   for (genvar i = 0; i < 2; i++) begin : g_led
      logic [LW-1:0] c;
      always_ff @(posedge HCLK or negedge HRESETn)
         if (!HRESETn) c <= '0;
         else if (led_hit[i]) c <= LW'(LED_HOLD);
         else if (c != '0) c <= c - 1'b1;
      assign leds_o[i] = |c;
   end
`else
   localparam int unused_led_hold = LED_HOLD;
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: scoreboard bench over three controller configurations
// (32-bit zero-wait, 32-bit two read waits, 64-bit zero-wait) sharing one bus.
module tb_ahb_sram_ctrl;

   typedef struct {
      logic        rd;
      logic [63:0] data;
      logic        err;
      int          waits;
      logic [3:0]  dwe;
   } exp_t;

   exp_t sb[$];

   logic        HCLK = 1'b0, HRESETn = 1'b0;
   logic        HSEL = 1'b0, HWRITE = 1'b0;
   logic [31:0] HADDR = '0;
   logic [2:0]  HSIZE = '0;
   logic [1:0]  HTRANS = '0;
   logic [63:0] HWDATA = '0;
   logic        hr_force0 = 1'b0, done = 1'b0;
   int          dsel = 0;

   logic [31:0] rd0, rd2;
   logic [63:0] rd64;
   logic        ro0, ro2, ro64, rs0, rs2, rs64;
   logic        sel_ready, bus_hready, mon_ready, mon_resp;
   logic [63:0] mon_rdata;

   always #5 HCLK = ~HCLK;

   assign sel_ready  = (dsel == 0) ? ro0 : (dsel == 1) ? ro2 : ro64;
   assign bus_hready = !hr_force0 && sel_ready;
   assign mon_ready  = sel_ready;
   assign mon_resp   = (dsel == 0) ? rs0 : (dsel == 1) ? rs2 : rs64;
   assign mon_rdata  = (dsel == 0) ? {32'b0, rd0} : (dsel == 1) ? {32'b0, rd2} : rd64;

   ahb_sram_ctrl #(.DATA_W(32), .RD_WAIT(0)) u0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL && dsel == 0), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HREADY(bus_hready),
      .HWDATA(HWDATA[31:0]), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

   ahb_sram_ctrl #(.DATA_W(32), .RD_WAIT(2)) u2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL && dsel == 1), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HREADY(bus_hready),
      .HWDATA(HWDATA[31:0]), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

   ahb_sram_ctrl #(.DATA_W(64), .RD_WAIT(0)) u64 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL && dsel == 2), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HREADY(bus_hready),
      .HWDATA(HWDATA), .HRDATA(rd64), .HREADYOUT(ro64), .HRESP(rs64));

   // Monitor / scoreboard
   int   checks = 0, errors = 0, waits = 0;
   bit   pend = 0;
   exp_t e;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         chk("rst_hreadyout", 64'(mon_ready), 64'd1);
         chk("rst_hresp", 64'(mon_resp), 64'd0);
         chk("rst_hrdata", mon_rdata, 64'd0);
         sb.delete();
         pend = 0;
         waits = 0;
      end else begin
         if (pend) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty actual=completion expected=no_transfer");
               pend = 0;
            end else if (!mon_ready) begin
               if (sb[0].err) chk("err1_hresp", 64'(mon_resp), 64'd1);
               if (waits == 0 && sb[0].dwe != 4'd0) chk("drain_we", 64'(u2.ram_we), 64'(sb[0].dwe));
               waits++;
            end else begin
               e = sb.pop_front();
               chk("hresp", 64'(mon_resp), 64'(e.err));
               chk("waits", 64'(waits), 64'(e.waits));
               if (e.rd && !e.err) chk("hrdata", mon_rdata, e.data);
               pend = 0;
               waits = 0;
            end
         end
         if (HSEL && HTRANS[1] && bus_hready) pend = 1;
         if (done) begin
            chk("sb_drained", 64'(sb.size()) + 64'(pend), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   // Stimulus
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic ap(input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [63:0] d,
                     input bit err, input int nw, input logic [3:0] dwe);
      exp_t x;
      x.rd = !w; x.data = d; x.err = err; x.waits = nw; x.dwe = dwe;
      HSEL = 1'b1; HWRITE = w; HSIZE = sz; HADDR = a; HTRANS = 2'b10;
      sb.push_back(x);
      for (int t = 0; t < 16; t++) begin
         @(negedge HCLK);
         if (bus_hready) break;
      end
      @(posedge HCLK);
      #1;
      HTRANS = 2'b00;
      if (w) HWDATA = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      idle(1);
      // 32-bit, zero wait
      ap(1, 3'd2, 32'h10, 64'hDEADBEEF, 0, 0, 0);
      idle(2);
      ap(0, 3'd2, 32'h10, 64'hDEADBEEF, 0, 0, 0);
      ap(1, 3'd2, 32'h20, 64'h11223344, 0, 0, 0);
      idle(2);
      ap(1, 3'd0, 32'h21, 64'h0000AA00, 0, 0, 0);
      ap(0, 3'd2, 32'h20, 64'h1122AA44, 0, 0, 0);
      idle(2);
      ap(0, 3'd2, 32'h20, 64'h1122AA44, 0, 0, 0);
      ap(1, 3'd2, 32'h0, 64'h55667788, 0, 0, 0);
      idle(2);
      ap(1, 3'd1, 32'h2, 64'hBEEF0000, 0, 0, 0);
      ap(0, 3'd2, 32'h0, 64'hBEEF7788, 0, 0, 0);
      ap(1, 3'd2, 32'hFFFC, 64'hCAFEF00D, 0, 0, 0);
      ap(0, 3'd2, 32'hFFFC, 64'hCAFEF00D, 0, 0, 0);
      idle(2);
      ap(0, 3'd2, 32'hFFFC, 64'hCAFEF00D, 0, 0, 0);
      // illegal accesses
      ap(0, 3'd2, 32'h10000, 64'h0, 1, 1, 0);
      ap(1, 3'd1, 32'h3, 64'hFFFFFFFF, 1, 1, 0);
      ap(1, 3'd3, 32'h8, 64'hFFFFFFFF, 1, 1, 0);
      ap(1, 3'd2, 32'h2, 64'hFFFFFFFF, 1, 1, 0);
      idle(2);
      ap(0, 3'd2, 32'h0, 64'hBEEF7788, 0, 0, 0);
      // selected but HREADY low: no access
      HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h0; HTRANS = 2'b10; hr_force0 = 1'b1;
      idle(1);
      HWDATA = 64'h0;
      idle(2);
      HTRANS = 2'b00; hr_force0 = 1'b0;
      idle(2);
      ap(0, 3'd2, 32'h0, 64'hBEEF7788, 0, 0, 0);
      // reset during ERR1
      ap(0, 3'd2, 32'h10000, 64'h0, 1, 1, 0);
      HRESETn = 1'b0;
      idle(2);
      HRESETn = 1'b1;
      idle(1);
      ap(0, 3'd2, 32'h10, 64'hDEADBEEF, 0, 0, 0);
      idle(2);
      // 32-bit, two read wait states
      dsel = 1;
      ap(1, 3'd2, 32'h40, 64'h0BADF00D, 0, 0, 0);
      idle(2);
      ap(1, 3'd2, 32'h44, 64'h44444444, 0, 0, 0);
      ap(0, 3'd2, 32'h40, 64'h0BADF00D, 0, 2, 4'hF);
      ap(0, 3'd2, 32'h44, 64'h44444444, 0, 2, 0);
      ap(0, 3'd2, 32'h40, 64'h0BADF00D, 0, 2, 0);
      idle(4);
      // 64-bit
      dsel = 2;
      ap(1, 3'd3, 32'h0, 64'h0, 0, 0, 0);
      idle(2);
      ap(1, 3'd2, 32'h4, 64'h01234567_00000000, 0, 0, 0);
      ap(0, 3'd3, 32'h0, 64'h01234567_00000000, 0, 0, 0);
      idle(2);
      ap(0, 3'd3, 32'h0, 64'h01234567_00000000, 0, 0, 0);
      ap(1, 3'd2, 32'h2, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 0);
      ap(0, 3'd2, 32'h4, 64'h01234567_00000000, 0, 0, 0);
      idle(3);
      done = 1'b1;
   end

endmodule
